// File: rtl/truth_table_scanner.sv
// Truth-table scanner: drives all eight {x,y,z} codes into a 3-input CUT, samples f_in, compares to expected.
// Optional build macro SCAN_MISMATCH_COUNT_EN adds the err_count mismatch counter output.
module truth_table_scanner #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] expected,
   input  logic       f_in,
   output logic       x,
   output logic       y,
   output logic       z,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
`ifdef SCAN_MISMATCH_COUNT_EN
   output logic [3:0] err_count,
`endif
   output logic       match
);

   // state    | meaning
   // S_IDLE   | waiting for start; outputs hold the last scan result
   // S_SETTLE | current code driven, settle timer running down
   // S_SAMPLE | capture f_in for the current index, advance or finish
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2
   } state_t;

   // Down-counter reload: SETTLE settle cycles end at terminal count zero.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [2:0] idx;
   logic [7:0] exp_q;
   logic       accept;
   logic       cnt_tc;
   logic       sample;
   logic       last;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start)  state_nxt = S_SETTLE;
         S_SETTLE: if (cnt_tc) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = (idx == 3'd7) ? S_IDLE : S_SETTLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      accept = (state == S_IDLE) && start;
      cnt_tc = (state == S_SETTLE) && (cnt == 4'd0);
      sample = (state == S_SAMPLE);
      last   = sample && (idx == 3'd7);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {x, y, z} <= 3'b000;
         busy      <= 1'b0;
         done      <= 1'b0;
         match     <= 1'b0;
         table_out <= 8'h00;
         exp_q     <= 8'h00;
         idx       <= 3'd0;
         cnt       <= 4'd0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            exp_q     <= expected;
            table_out <= 8'h00;
            match     <= 1'b0;
            idx       <= 3'd0;
            {x, y, z} <= 3'b000;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
         end
         if ((state == S_SETTLE) && !cnt_tc) cnt <= cnt - 4'd1;
         if (sample) begin
            table_out[idx] <= f_in;
            if (last) begin
               // Bit 7 lands on this same edge, so compare using the live sample.
               match <= ({f_in, table_out[6:0]} == exp_q);
               done  <= 1'b1;
               busy  <= 1'b0;
            end else begin
               idx       <= idx + 3'd1;
               {x, y, z} <= idx + 3'd1;
               cnt       <= CNT_LOAD;
            end
         end
      end
   end

`ifdef SCAN_MISMATCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)                            err_count <= 4'd0;
      else if (accept)                    err_count <= 4'd0;
      else if (sample && (f_in != exp_q[idx])) err_count <= err_count + 4'd1;
   end
`endif

endmodule
